// File: rtl/calc_pkg.sv
// Shared definitions for the N-digit calculator core: key op codes,
// controller state encoding and the DIGITS-derived magnitude limit.
package calc_pkg;

    // Operator key codes as they arrive on the op port
    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_MUL     = 3'd2,
        OP_DIV     = 3'd3,
        OP_EQ      = 3'd4,
        OP_MPLUS   = 3'd5,
        OP_MRECALL = 3'd6,
        OP_MCLEAR  = 3'd7
    } op_t;

    // Controller states, visible on the debug state port
    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_OPE      = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    // Largest magnitude representable with the given number of decimal digits
    function automatic int calc_max(input int digits);
        int m;
        m = 1;
        for (int i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/calc_seq_div.sv
// Unsigned restoring divider, one quotient bit per clock.
// A start pulse loads the operands and performs the first step in the same
// cycle, so done pulses exactly W cycles after the start cycle. The quotient
// holds until the next start; abort cancels a running division.
module calc_seq_div #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_reg;
    logic [W-1:0]  quot_reg;
    logic [W-1:0]  dvsr_reg;
    logic [CW-1:0] cnt_reg;
    logic          done_reg;

    logic [W-1:0]  rem_in;
    logic [W-1:0]  quot_in;
    logic [W-1:0]  dvsr_in;
    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic [W-1:0]  rem_step;
    logic [W-1:0]  quot_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_in  = start ? '0 : rem_reg;
        quot_in = start ? dividend : quot_reg;
        dvsr_in = start ? divisor : dvsr_reg;
        shifted = {rem_in, quot_in[W-1]};
        trial   = shifted - {1'b0, dvsr_in};
        if (!trial[W]) begin
            rem_step  = trial[W-1:0];
            quot_step = (quot_in << 1) | W'(1);
        end else begin
            rem_step  = shifted[W-1:0];
            quot_step = quot_in << 1;
        end
    end

    // Iteration counter and partial remainder/quotient registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_reg  <= '0;
            quot_reg <= '0;
            dvsr_reg <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else if (abort) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else if (start) begin
            rem_reg  <= rem_step;
            quot_reg <= quot_step;
            dvsr_reg <= divisor;
            cnt_reg  <= CW'(W - 1);
            done_reg <= (W == 1);
        end else if (cnt_reg != '0) begin
            rem_reg  <= rem_step;
            quot_reg <= quot_step;
            cnt_reg  <= cnt_reg - CW'(1);
            done_reg <= (cnt_reg == CW'(1));
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign quotient = quot_reg;
    assign done     = done_reg;

endmodule

// File: rtl/calc_core_n.sv
// N-digit signed decimal calculator core. Chains ADD/SUB/MUL/DIV/EQ on
// single-cycle key pulses; DIV runs on calc_seq_div while busy is high.
// Display is sign + binary magnitude, combinational from the registers.
// Optional memory register (MPLUS/MRECALL/MCLEAR) is enabled by defining
// the macro CALC_MEM_EN; without it op codes 5..7 are ignored.
module calc_core_n
    import calc_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int ACC_W  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic             ce,
    input  logic             ac,
    output logic [ACC_W-2:0] out_mag,
    output logic             out_neg,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       state
);

    localparam int W     = ACC_W - 1;
    localparam int CW    = $clog2(DIGITS + 1);
    localparam int MAX_I = calc_max(DIGITS);
    localparam logic signed [2*ACC_W-1:0] MAX_W = (2*ACC_W)'(MAX_I);

    state_t                   state_reg, state_next;
    logic signed [ACC_W-1:0]  rega_reg, rega_next;
    logic signed [ACC_W-1:0]  regb_reg, regb_next;
    logic [CW-1:0]            count_reg, count_next;
    op_t                      pend_reg, pend_next;
    logic                     div_neg_reg, div_neg_next;
`ifdef CALC_MEM_EN
    logic signed [ACC_W-1:0]  mem_reg, mem_next;
    logic signed [ACC_W-1:0]  disp_val;
    logic signed [2*ACC_W-1:0] mem_sum;
    logic                     mem_ovf;
`endif

    logic                     digit_ok;
    logic                     op_arith;
    logic signed [ACC_W-1:0]  digit_ext;
    logic signed [ACC_W-1:0]  rega_shift;
    logic signed [2*ACC_W-1:0] a_w, b_w, arith_res;
    logic                     arith_ovf;
    logic [W-1:0]             rega_mag, regb_mag;
    logic signed [ACC_W-1:0]  quot_ext;
    logic                     div_start;
    logic [W-1:0]             div_quot;
    logic                     div_done;

    assign digit_ok   = digit_valid && (digit <= 4'd9);
    assign op_arith   = (op <= 3'd4);
    assign digit_ext  = {{(ACC_W-4){1'b0}}, digit};
    assign rega_shift = (rega_reg <<< 3) + (rega_reg <<< 1) + digit_ext;
    assign a_w        = {{ACC_W{rega_reg[ACC_W-1]}}, rega_reg};
    assign b_w        = {{ACC_W{regb_reg[ACC_W-1]}}, regb_reg};
    assign rega_mag   = W'(rega_reg[ACC_W-1] ? -rega_reg : rega_reg);
    assign regb_mag   = W'(regb_reg[ACC_W-1] ? -regb_reg : regb_reg);
    assign quot_ext   = {1'b0, div_quot};

    // Single-cycle arithmetic at double width so the range check never wraps
    always_comb begin
        case (pend_reg)
            OP_SUB:  arith_res = b_w - a_w;
            OP_MUL:  arith_res = b_w * a_w;
            default: arith_res = b_w + a_w;
        endcase
        arith_ovf = (arith_res > MAX_W) || (arith_res < -MAX_W);
    end

`ifdef CALC_MEM_EN
    // Memory accumulate uses whatever the display currently shows
    always_comb begin
        disp_val = (state_reg == ST_ENTRY) ? rega_reg : regb_reg;
        mem_sum  = {{ACC_W{mem_reg[ACC_W-1]}}, mem_reg}
                 + {{ACC_W{disp_val[ACC_W-1]}}, disp_val};
        mem_ovf  = (mem_sum > MAX_W) || (mem_sum < -MAX_W);
    end
`endif

    // Divider works on magnitudes; the core re-applies the sign on completion
    calc_seq_div #(
        .W(W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (ac),
        .dividend (regb_mag),
        .divisor  (rega_mag),
        .quotient (div_quot),
        .done     (div_done)
    );

    // Controller registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_ENTRY;
            rega_reg    <= '0;
            regb_reg    <= '0;
            count_reg   <= '0;
            pend_reg    <= OP_ADD;
            div_neg_reg <= 1'b0;
`ifdef CALC_MEM_EN
            mem_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            rega_reg    <= rega_next;
            regb_reg    <= regb_next;
            count_reg   <= count_next;
            pend_reg    <= pend_next;
            div_neg_reg <= div_neg_next;
`ifdef CALC_MEM_EN
            mem_reg     <= mem_next;
`endif
        end
    end

    // Next-state logic; key priority is ac > ce > op > digit
    always_comb begin
        state_next   = state_reg;
        rega_next    = rega_reg;
        regb_next    = regb_reg;
        count_next   = count_reg;
        pend_next    = pend_reg;
        div_neg_next = div_neg_reg;
        div_start    = 1'b0;
`ifdef CALC_MEM_EN
        mem_next     = mem_reg;
`endif
        if (ac) begin
            state_next   = ST_ENTRY;
            rega_next    = '0;
            regb_next    = '0;
            count_next   = '0;
            pend_next    = OP_ADD;
            div_neg_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ENTRY: begin
                    if (ce) begin
                        rega_next  = '0;
                        count_next = '0;
                    end else if (op_valid) begin
                        if (op_arith) begin
                            pend_next = op_t'(op);
                            if (pend_reg == OP_DIV) begin
                                if (rega_reg == '0) begin
                                    state_next = ST_HALT;
                                end else begin
                                    div_start    = 1'b1;
                                    div_neg_next = regb_reg[ACC_W-1] ^ rega_reg[ACC_W-1];
                                    state_next   = ST_DIV_BUSY;
                                end
                            end else if (pend_reg == OP_EQ) begin
                                regb_next  = rega_reg;
                                state_next = ST_OPE;
                            end else if (arith_ovf) begin
                                state_next = ST_HALT;
                            end else begin
                                regb_next  = arith_res[ACC_W-1:0];
                                state_next = ST_OPE;
                            end
                        end
                    end else if (digit_ok && (count_reg < CW'(DIGITS))) begin
                        rega_next  = rega_shift;
                        count_next = count_reg + CW'(1);
                    end
                end
                ST_OPE: begin
                    if (ce) begin
                        // clear-entry has nothing to clear while showing a result
                    end else if (op_valid) begin
                        if (op_arith) begin
                            pend_next = op_t'(op);
                        end
                    end else if (digit_ok) begin
                        rega_next  = digit_ext;
                        count_next = CW'(1);
                        state_next = ST_ENTRY;
                        if (pend_reg == OP_EQ) begin
                            regb_next = '0;
                            pend_next = OP_ADD;
                        end
                    end
                end
                ST_DIV_BUSY: begin
                    if (div_done) begin
                        regb_next  = div_neg_reg ? -quot_ext : quot_ext;
                        state_next = ST_OPE;
                    end
                end
                ST_HALT: begin
                    if (ce) begin
                        state_next   = ST_ENTRY;
                        rega_next    = '0;
                        regb_next    = '0;
                        count_next   = '0;
                        pend_next    = OP_ADD;
                        div_neg_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_ENTRY;
                end
            endcase
`ifdef CALC_MEM_EN
            if (!ce && op_valid && !op_arith &&
                (state_reg == ST_ENTRY || state_reg == ST_OPE)) begin
                case (op_t'(op))
                    OP_MPLUS: begin
                        if (mem_ovf) begin
                            state_next = ST_HALT;
                        end else begin
                            mem_next = mem_sum[ACC_W-1:0];
                        end
                    end
                    OP_MRECALL: begin
                        rega_next  = mem_reg;
                        count_next = CW'(DIGITS);
                        state_next = ST_ENTRY;
                    end
                    OP_MCLEAR: begin
                        mem_next = '0;
                    end
                    default: begin
                    end
                endcase
            end
`endif
        end
    end

    // Display: entry operand while typing, signed result otherwise, blank on halt
    always_comb begin
        out_mag = '0;
        out_neg = 1'b0;
        case (state_reg)
            ST_ENTRY: begin
                out_mag = rega_mag;
                // a recalled memory value may be negative
                out_neg = rega_reg[ACC_W-1];
            end
            ST_HALT: begin
                out_mag = '0;
                out_neg = 1'b0;
            end
            default: begin
                out_mag = regb_mag;
                out_neg = regb_reg[ACC_W-1];
            end
        endcase
    end

    assign state    = state_reg;
    assign overflow = (state_reg == ST_HALT);
    assign busy     = (state_reg == ST_DIV_BUSY);

endmodule

// File: tb/tb_calc_core_n.sv
// Self-checking bench for calc_core_n (default build, memory disabled).
// Directed key sequences with fixed expected values, then random key
// streams checked against an integer-arithmetic calculator model.
module tb_calc_core_n;

    localparam int ACC_W = 12;
    localparam int MAXV  = 999;
    localparam int DIV_CYCLES = ACC_W - 1;

    logic             clk;
    logic             reset;
    logic             digit_valid;
    logic [3:0]       digit;
    logic             op_valid;
    logic [2:0]       op;
    logic             ce;
    logic             ac;
    logic [ACC_W-2:0] out_mag;
    logic             out_neg;
    logic             overflow;
    logic             busy;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    // model: a = entry operand, b = result, st 0 entry/1 result/3 halted
    int  ma, mb, mcnt, mpend, mst;
    bit  mdiv;
    bit  inject_busy = 0;
    bit  abort_div   = 0;

    calc_core_n #(
        .DIGITS(3),
        .ACC_W (ACC_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .op_valid    (op_valid),
        .op          (op),
        .ce          (ce),
        .ac          (ac),
        .out_mag     (out_mag),
        .out_neg     (out_neg),
        .overflow    (overflow),
        .busy        (busy),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        ma = 0; mb = 0; mcnt = 0; mpend = 0; mst = 0;
    endtask

    // kind: 0 digit, 1 operator, 2 clear-entry, 3 all-clear
    task automatic model_key(input int kind, input int val);
        int  r;
        bit  bad;
        mdiv = 0;
        if (kind == 3) begin
            model_clear();
        end else if (mst == 0) begin
            if (kind == 2) begin
                ma = 0; mcnt = 0;
            end else if (kind == 1 && val <= 4) begin
                bad = 0;
                r   = 0;
                case (mpend)
                    0: r = mb + ma;
                    1: r = mb - ma;
                    2: r = mb * ma;
                    3: if (ma == 0) bad = 1; else begin r = mb / ma; mdiv = 1; end
                    default: r = ma;
                endcase
                if (!bad && (r > MAXV || r < -MAXV)) bad = 1;
                if (bad) mst = 3;
                else begin mb = r; mst = 1; end
                mpend = val;
            end else if (kind == 0 && val <= 9 && mcnt < 3) begin
                ma = ma * 10 + val;
                mcnt++;
            end
        end else if (mst == 1) begin
            if (kind == 1 && val <= 4) begin
                mpend = val;
            end else if (kind == 0 && val <= 9) begin
                if (mpend == 4) begin mb = 0; mpend = 0; end
                ma = val; mcnt = 1; mst = 0;
            end
        end else if (mst == 3) begin
            if (kind == 2) model_clear();
        end
    endtask

    task automatic check_display(input string tag);
        int emag, eneg;
        if (mst == 0) begin emag = ma; eneg = 0; end
        else if (mst == 3) begin emag = 0; eneg = 0; end
        else begin emag = (mb < 0) ? -mb : mb; eneg = (mb < 0) ? 1 : 0; end
        check_val({tag, "_state"}, int'(state), mst);
        check_val({tag, "_mag"}, int'(out_mag), emag);
        if (mst != 3) check_val({tag, "_neg"}, int'(out_neg), eneg);
        check_val({tag, "_ovf"}, int'(overflow), (mst == 3) ? 1 : 0);
        check_val({tag, "_busy"}, int'(busy), 0);
    endtask

    // kind 4 presses operator val together with digit 7 (digit must be dropped)
    task automatic press(input int kind, input int val);
        int n;
        bit aborted;
        case (kind)
            0: begin digit_valid = 1; digit = 4'(val); end
            1: begin op_valid = 1; op = 3'(val); end
            2: ce = 1;
            3: ac = 1;
            default: begin op_valid = 1; op = 3'(val); digit_valid = 1; digit = 4'd7; end
        endcase
        @(posedge clk); #1;
        digit_valid = 0; op_valid = 0; ce = 0; ac = 0;
        model_key((kind == 4) ? 1 : kind, val);
        if (mdiv) begin
            check_val("div_busy_start", int'(busy), 1);
            n = 0;
            aborted = 0;
            while (busy && n < 100) begin
                n++;
                if (abort_div && n == 3) begin
                    ac = 1;
                    @(posedge clk); #1;
                    ac = 0;
                    model_key(3, 0);
                    check_val("div_abort_busy", int'(busy), 0);
                    aborted = 1;
                    break;
                end
                if (inject_busy && n == 2) begin
                    digit_valid = 1; digit = 4'd5; op_valid = 1; op = 3'd0;
                end
                @(posedge clk); #1;
                digit_valid = 0; op_valid = 0;
            end
            if (!aborted) check_val("div_cycles", n, DIV_CYCLES);
        end
        $display("key kind=%0d val=%0d -> state=%0d mag=%0d neg=%0d ovf=%0d",
                 kind, val, state, out_mag, out_neg, overflow);
        check_display("key");
    endtask

    initial begin
        int r, kind, val;
        reset = 0; digit_valid = 0; digit = 0; op_valid = 0; op = 0; ce = 0; ac = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state", int'(state), 0);
        check_val("rst_mag", int'(out_mag), 0);
        check_val("rst_neg", int'(out_neg), 0);
        check_val("rst_ovf", int'(overflow), 0);
        check_val("rst_busy", int'(busy), 0);
        reset = 1;
        @(posedge clk); #1;

        // 12 + 34
        press(0, 1); press(0, 2); press(1, 0); press(0, 3); press(0, 4); press(1, 4);
        check_val("t1_mag", int'(out_mag), 46);
        check_val("t1_neg", int'(out_neg), 0);
        check_val("t1_state", int'(state), 1);

        // 7 - 9 gives -2, next digit starts a fresh calculation
        press(0, 7); press(1, 1); press(0, 9); press(1, 4);
        check_val("t2_mag", int'(out_mag), 2);
        check_val("t2_neg", int'(out_neg), 1);
        press(0, 5);
        check_val("t2_fresh_mag", int'(out_mag), 5);
        press(1, 0); press(0, 1); press(1, 4);
        check_val("t2_fresh_sum", int'(out_mag), 6);
        press(3, 0);

        // digit limit and clear-entry
        press(0, 1); press(0, 2); press(0, 3); press(0, 4);
        check_val("t3_mag", int'(out_mag), 123);
        press(2, 0);
        check_val("t3_ce", int'(out_mag), 0);

        // 999 * 2 overflows, ce recovers
        press(0, 9); press(0, 9); press(0, 9); press(1, 2); press(0, 2); press(1, 4);
        check_val("t4_ovf", int'(overflow), 1);
        check_val("t4_state", int'(state), 3);
        check_val("t4_mag", int'(out_mag), 0);
        press(2, 0);
        check_val("t4_ce_state", int'(state), 0);
        check_val("t4_ce_mag", int'(out_mag), 0);

        // 100 / 7 = 14, then divide by zero halts
        press(3, 0);
        press(0, 1); press(0, 0); press(0, 0); press(1, 3); press(0, 7); press(1, 4);
        check_val("t5_mag", int'(out_mag), 14);
        press(0, 5); press(1, 3); press(0, 0); press(1, 4);
        check_val("t5_div0_state", int'(state), 3);

        // ac mid-division aborts and clears everything
        press(3, 0);
        abort_div = 1;
        press(0, 8); press(0, 4); press(1, 3); press(0, 4); press(1, 4);
        abort_div = 0;
        check_val("t6_state", int'(state), 0);
        check_val("t6_mag", int'(out_mag), 0);
        press(0, 3); press(1, 0);
        check_val("t6_regb_clear", int'(out_mag), 3);

        // keys during busy are ignored; negative quotient truncates toward zero
        press(3, 0);
        inject_busy = 1;
        press(0, 9); press(1, 3); press(0, 2); press(1, 4);
        inject_busy = 0;
        check_val("t7_mag", int'(out_mag), 4);
        press(0, 3); press(1, 1); press(0, 9); press(1, 4);
        press(1, 3); press(0, 4); press(1, 4);
        check_val("t7_negdiv_mag", int'(out_mag), 1);
        check_val("t7_negdiv_neg", int'(out_neg), 1);

        // digit arriving together with an operator is dropped
        press(3, 0);
        press(0, 5); press(4, 0); press(0, 2); press(1, 4);
        check_val("t8_mag", int'(out_mag), 7);

        // memory ops are inert without the memory option
        press(3, 0);
        press(0, 4); press(0, 2); press(1, 5);
        check_val("t9_mplus_mag", int'(out_mag), 42);
        press(3, 0); press(1, 6);
        check_val("t9_mrecall_state", int'(state), 0);
        check_val("t9_mrecall_mag", int'(out_mag), 0);

        // random key stream against the model
        press(3, 0);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 58) begin
                kind = 0; val = int'($urandom_range(0, 11));
            end else if (r < 90) begin
                kind = 1; val = int'($urandom_range(0, 7));
            end else if (r < 98) begin
                kind = 2; val = 0;
            end else begin
                kind = 3; val = 0;
            end
            press(kind, val);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
